can_clic_core: RTL
==================

CAN_CLIC_CORE -- requirements
Module: can_clic_core

Interface
REQ-001 SHALL have parameter NR_SRC, default 8: number of interrupt sources.
REQ-002 SHALL have parameter PRIO_W, default 2: priority width in bits.
REQ-003 SHALL have parameter STACK_DEPTH, default 4: maximum preemption nesting.
REQ-004 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, synchronous and active-low.
REQ-006 SHALL have port irq_i  in  NR_SRC  per-source interrupt lines.
REQ-007 SHALL have port cfg_we  in  1  configuration write strobe.
REQ-008 SHALL have port cfg_idx  in  $clog2(NR_SRC+1)  entry index; value NR_SRC selects the base threshold.
REQ-009 SHALL have port cfg_prio  in  PRIO_W  priority (or threshold) value written.
REQ-010 SHALL have port cfg_en  in  1  source enable written; ignored for the threshold entry.
REQ-011 SHALL have port req_valid  out  1  a claimable interrupt is presented.
REQ-012 SHALL have port req_idx  out  $clog2(NR_SRC)  index of the presented source.
REQ-013 SHALL have port req_prio  out  PRIO_W  priority of the presented source.
REQ-014 SHALL have port req_ready  in  1  core claims the presented interrupt.
REQ-015 SHALL have port ret_i  in  1  return from the current handler (pop).
REQ-016 SHALL have port depth_o  out  $clog2(STACK_DEPTH+1)  current nesting depth.
REQ-017 SHALL have port ret_err  out  1  sticky flag: ret_i received with an empty stack.

Function
REQ-018 Candidate set SHALL be the sources that are pending, enabled and have prio strictly greater than the current threshold.
REQ-019 Current threshold SHALL be thr_base when depth==0, otherwise the stack top.
REQ-020 Winner SHALL be the candidate with maximum prio; ties SHALL go to the highest index.
REQ-021 req_valid/req_idx/req_prio SHALL be registered, with one cycle of latency from the state that produced them.
REQ-022 When there is no candidate, req_valid SHALL be 0 and req_idx/req_prio SHALL be 0.
REQ-023 A claim SHALL occur when req_valid&&req_ready: push req_prio, increment depth.
REQ-024 req_valid SHALL be 0 in the cycle after a claim, so that no stale double-claim is possible.
REQ-025 When depth==STACK_DEPTH, req_valid SHALL be forced to 0 (no further preemption).
REQ-026 ret_i with depth>0 SHALL pop the stack and decrement depth.
REQ-027 ret_i with depth==0 SHALL leave the state unchanged and set ret_err, which is cleared only by reset.
REQ-028 Simultaneous claim and ret_i SHALL pop then push: depth is unchanged and the top is replaced by the claimed prio.
REQ-029 A cfg write SHALL take effect on the next edge and SHALL be visible on req_* one cycle later.
REQ-030 A cfg_idx greater than NR_SRC SHALL be ignored.
REQ-031 Without the macro in REQ-035, pending SHALL equal irq_i registered once (level mode); a claim does not clear it.

Reset
REQ-032 On rst_n==0 at a clock edge, the block SHALL clear: all prio, enable and pending state; thr_base; the stack; depth.
REQ-033 On the same reset, all outputs SHALL be 0: req_valid, req_idx, req_prio, depth_o, ret_err.
REQ-034 A reset mid-nesting SHALL discard all stack content, with no output glitch other than going to the reset values.

Configuration
REQ-035 The macro CAN_CLIC_EDGE_EN SHALL select edge mode: a rising edge on irq_i sets pending, and a claim of that index clears it.
REQ-036 In edge mode, a new edge coinciding with the claim of the same index SHALL leave pending set.
REQ-037 Without CAN_CLIC_EDGE_EN, no edge-detect registers SHALL exist and level mode (REQ-031) SHALL apply.

Structure
REQ-038 common_pkg SHALL hold typedefs Prio, Index and Entry (prio+en), plus the default parameter constants.
REQ-039 Combinational max-priority selection SHALL live in a sub-module can_clic_arbiter (parametrised NR_SRC, PRIO_W; tie to the highest index).
REQ-040 Stack and depth logic SHALL reside in can_clic_core.

Verification (NR_SRC=8, PRIO_W=2, STACK_DEPTH=2)
REQ-041 Scenario: thr_base=1; srcs 0,3,4 enabled with prio 1 and pending -> req_valid=0.
REQ-042 Scenario: thr_base=0, same srcs -> req_valid=1, req_idx=4, req_prio=1 one cycle after the cfg write.
REQ-043 Scenario: claim idx4 (prio1); then src6 prio3 pending -> req_idx=6 presented; claim -> depth_o=2; src5 prio3 rises -> req_valid stays 0 (stack full).
REQ-044 Scenario: ret_i at depth 0 -> ret_err=1, depth_o=0; ret_err stays 1 until reset.
REQ-045 Scenario: claim and ret_i in the same cycle at depth 1 -> depth_o=1, and the threshold equals the claimed prio.
REQ-046 Scenario: rst_n=0 for one cycle at depth 2 -> all outputs 0 next cycle; a prior cfg must be rewritten before any req_valid.

Source files
------------

// File: rtl/common_pkg.sv
//==============================================================================
// common_pkg: shared types and default sizing for the CLIC interrupt core.
// Rev 1.0
//==============================================================================
`default_nettype none

package common_pkg;

    localparam int DEFAULT_NR_SRC      = 8;
    localparam int DEFAULT_PRIO_W      = 2;
    localparam int DEFAULT_STACK_DEPTH = 4;

    typedef logic [DEFAULT_PRIO_W-1:0]          Prio;
    typedef logic [$clog2(DEFAULT_NR_SRC)-1:0]  Index;

    typedef struct packed {
        Prio  prio;
        logic en;
    } Entry;

endpackage

`default_nettype wire

// File: rtl/can_clic_arbiter.sv
//==============================================================================
// can_clic_arbiter: combinational max-priority pick, ties to the highest index.
// Rev 1.0
//==============================================================================
`default_nettype none

module can_clic_arbiter
    import common_pkg::*;
#(
    parameter  int NR_SRC = DEFAULT_NR_SRC,
    parameter  int PRIO_W = DEFAULT_PRIO_W,
    localparam int IW     = $clog2(NR_SRC)
) (
    input  logic [NR_SRC-1:0]             cand_i,
    input  logic [NR_SRC-1:0][PRIO_W-1:0] prio_i,
    output logic                          valid_o,
    output logic [IW-1:0]                 idx_o,
    output logic [PRIO_W-1:0]             prio_o
);

    // Ascending scan with >= lets a later (higher) index win an equal priority.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        prio_o  = '0;
        for (int i = 0; i < NR_SRC; i++) begin
            if (cand_i[i] && (!valid_o || (prio_i[i] >= prio_o))) begin
                valid_o = 1'b1;
                idx_o   = IW'(i);
                prio_o  = prio_i[i];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/can_clic_core.sv
//==============================================================================
// can_clic_core: prioritised interrupt presenter with a preemption stack.
// Build macro CAN_CLIC_EDGE_EN selects edge-triggered pending (default: level).
// Rev 1.0
//==============================================================================
`default_nettype none

module can_clic_core
    import common_pkg::*;
#(
    parameter  int NR_SRC      = DEFAULT_NR_SRC,
    parameter  int PRIO_W      = DEFAULT_PRIO_W,
    parameter  int STACK_DEPTH = DEFAULT_STACK_DEPTH,
    localparam int IW          = $clog2(NR_SRC),
    localparam int CW          = $clog2(NR_SRC + 1),
    localparam int DW          = $clog2(STACK_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NR_SRC-1:0] irq_i,
    input  logic              cfg_we,
    input  logic [CW-1:0]     cfg_idx,
    input  logic [PRIO_W-1:0] cfg_prio,
    input  logic              cfg_en,
    output logic              req_valid,
    output logic [IW-1:0]     req_idx,
    output logic [PRIO_W-1:0] req_prio,
    input  logic              req_ready,
    input  logic              ret_i,
    output logic [DW-1:0]     depth_o,
    output logic              ret_err
);

    logic [NR_SRC-1:0][PRIO_W-1:0]      src_prio_q;
    logic [NR_SRC-1:0]                  en_q;
    logic [NR_SRC-1:0]                  pend_q;
    logic [NR_SRC-1:0]                  pend_d;
    logic [PRIO_W-1:0]                  thr_base_q;
    logic [STACK_DEPTH-1:0][PRIO_W-1:0] stack_q;
    logic [STACK_DEPTH-1:0][PRIO_W-1:0] stack_d;
    logic [DW-1:0]                      depth_q;
    logic [DW-1:0]                      depth_d;
    logic                               ret_err_q;
    logic                               req_valid_q;
    logic [IW-1:0]                      req_idx_q;
    logic [PRIO_W-1:0]                  req_prio_q;

    logic [PRIO_W-1:0] thr_w;
    logic [NR_SRC-1:0] cand_w;
    logic              full_w;
    logic              claim_w;
    logic              pop_w;
    logic              arb_valid_w;
    logic [IW-1:0]     arb_idx_w;
    logic [PRIO_W-1:0] arb_prio_w;

    assign full_w  = (depth_q == DW'(STACK_DEPTH));
    assign claim_w = req_valid_q && req_ready;
    assign pop_w   = ret_i && (depth_q != '0);

    always_comb begin
        thr_w = thr_base_q;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (depth_q == DW'(i + 1)) begin
                thr_w = stack_q[i];
            end
        end
    end

    always_comb begin
        cand_w = '0;
        for (int i = 0; i < NR_SRC; i++) begin
            cand_w[i] = pend_q[i] && en_q[i] && (src_prio_q[i] > thr_w);
        end
    end

    can_clic_arbiter #(
        .NR_SRC (NR_SRC),
        .PRIO_W (PRIO_W)
    ) u_arbiter (
        .cand_i  (cand_w),
        .prio_i  (src_prio_q),
        .valid_o (arb_valid_w),
        .idx_o   (arb_idx_w),
        .prio_o  (arb_prio_w)
    );

    // Claim together with return overwrites the current top in place.
    always_comb begin
        stack_d = stack_q;
        depth_d = depth_q;
        if (claim_w && pop_w) begin
            for (int i = 0; i < STACK_DEPTH; i++) begin
                if (depth_q == DW'(i + 1)) begin
                    stack_d[i] = req_prio_q;
                end
            end
        end else if (claim_w && !full_w) begin
            for (int i = 0; i < STACK_DEPTH; i++) begin
                if (depth_q == DW'(i)) begin
                    stack_d[i] = req_prio_q;
                end
            end
            depth_d = depth_q + DW'(1);
        end else if (pop_w) begin
            depth_d = depth_q - DW'(1);
        end
    end

`ifdef CAN_CLIC_EDGE_EN
    logic [NR_SRC-1:0] irq_prev_q;
    logic [NR_SRC-1:0] rise_w;
    logic [NR_SRC-1:0] clr_w;

    // A fresh edge in the claim cycle wins over the claim's clear.
    always_comb begin
        rise_w = irq_i & ~irq_prev_q;
        clr_w  = claim_w ? (NR_SRC'(1) << req_idx_q) : '0;
        pend_d = (pend_q & ~clr_w) | rise_w;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            irq_prev_q <= '0;
        end else begin
            irq_prev_q <= irq_i;
        end
    end
`else
    assign pend_d = irq_i;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            src_prio_q  <= '0;
            en_q        <= '0;
            pend_q      <= '0;
            thr_base_q  <= '0;
            stack_q     <= '0;
            depth_q     <= '0;
            ret_err_q   <= 1'b0;
            req_valid_q <= 1'b0;
            req_idx_q   <= '0;
            req_prio_q  <= '0;
        end else begin
            pend_q  <= pend_d;
            stack_q <= stack_d;
            depth_q <= depth_d;
            if (ret_i && (depth_q == '0)) begin
                ret_err_q <= 1'b1;
            end
            for (int i = 0; i < NR_SRC; i++) begin
                if (cfg_we && (cfg_idx == CW'(i))) begin
                    src_prio_q[i] <= cfg_prio;
                    en_q[i]       <= cfg_en;
                end
            end
            if (cfg_we && (cfg_idx == CW'(NR_SRC))) begin
                thr_base_q <= cfg_prio;
            end
            // Suppress presentation right after a claim and while the stack is full.
            if (claim_w || full_w || !arb_valid_w) begin
                req_valid_q <= 1'b0;
                req_idx_q   <= '0;
                req_prio_q  <= '0;
            end else begin
                req_valid_q <= 1'b1;
                req_idx_q   <= arb_idx_w;
                req_prio_q  <= arb_prio_w;
            end
        end
    end

    assign req_valid = req_valid_q;
    assign req_idx   = req_idx_q;
    assign req_prio  = req_prio_q;
    assign depth_o   = depth_q;
    assign ret_err   = ret_err_q;

endmodule

`default_nettype wire
